// File: rtl/button_event_ctrl.sv
// Shared push-button front end: 2-FF sync, shared ms timebase, per-button debounce
// with short/long press classification, round-robin arbiter onto one valid/ready port.
module button_event_ctrl #(
  parameter int unsigned NUM_BTN  = 4,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DEB_MS   = 20,
  parameter int unsigned LONG_MS  = 5000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  input  logic               i_test_mode,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic               o_evt_valid,
  input  logic               i_evt_ready,
  output logic [2:0]         o_evt_btn,
  output logic               o_evt_long,
  output logic               o_overflow
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_MS + 1);
  localparam int unsigned HW = $clog2(LONG_MS + 1);
  localparam int unsigned IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DEB_P, S_PRESSED, S_DEB_R} state_t;

  logic [NUM_BTN-1:0] r_sync1, r_sync2;
  logic [PW-1:0]      r_pre;
  logic               w_tick;
  logic [NUM_BTN-1:0] w_post, w_post_long;

  // Synchroniser and shared prescaler; test_mode holds the prescaler at 0 so it restarts cleanly.
  assign w_tick = i_test_mode | (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_pre   <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      if (w_tick) r_pre <= '0;
      else        r_pre <= r_pre + PW'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_dcnt, w_dcnt_nxt, w_dinc;
    logic [HW-1:0] r_hcnt, w_hcnt_nxt, w_hinc;
    logic          r_long_done, w_long_done_nxt;
    logic          r_level, w_level_nxt;
    logic          w_post_i, w_post_long_i;

    assign w_dinc = r_dcnt + DW'(1);
    assign w_hinc = (r_hcnt == HW'(LONG_MS)) ? r_hcnt : r_hcnt + HW'(1);

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_state     <= S_IDLE;
        r_dcnt      <= '0;
        r_hcnt      <= '0;
        r_long_done <= 1'b0;
        r_level     <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_dcnt      <= w_dcnt_nxt;
        r_hcnt      <= w_hcnt_nxt;
        r_long_done <= w_long_done_nxt;
        r_level     <= w_level_nxt;
      end
    end

    // Event posts are decided alongside the transition so pend[] updates on the same edge.
    always_comb begin
      w_state_nxt     = r_state;
      w_dcnt_nxt      = r_dcnt;
      w_hcnt_nxt      = r_hcnt;
      w_long_done_nxt = r_long_done;
      w_level_nxt     = r_level;
      w_post_i        = 1'b0;
      w_post_long_i   = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_sync2[gi]) begin
            w_state_nxt = S_DEB_P;
            w_dcnt_nxt  = '0;
          end
        end
        S_DEB_P: begin
          if (!r_sync2[gi]) begin
            w_state_nxt = S_IDLE;
          end else if (w_tick) begin
            w_dcnt_nxt = w_dinc;
            if (w_dinc == DW'(DEB_MS)) begin
              w_state_nxt     = S_PRESSED;
              w_level_nxt     = 1'b1;
              w_hcnt_nxt      = '0;
              w_long_done_nxt = 1'b0;
            end
          end
        end
        S_PRESSED: begin
          if (w_tick) w_hcnt_nxt = w_hinc;
          if (!r_long_done && (w_hcnt_nxt == HW'(LONG_MS))) begin
            w_post_i        = 1'b1;
            w_post_long_i   = 1'b1;
            w_long_done_nxt = 1'b1;
          end
          if (!r_sync2[gi]) begin
            w_state_nxt = S_DEB_R;
            w_dcnt_nxt  = '0;
          end
        end
        S_DEB_R: begin
          if (w_tick) w_hcnt_nxt = w_hinc;
          if (r_sync2[gi]) begin
            w_state_nxt = S_PRESSED;
          end else if (w_tick) begin
            w_dcnt_nxt = w_dinc;
            if (w_dinc == DW'(DEB_MS)) begin
              w_state_nxt = S_IDLE;
              w_level_nxt = 1'b0;
              w_post_i    = !r_long_done;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    assign w_post[gi]      = w_post_i;
    assign w_post_long[gi] = w_post_long_i;
    assign o_btn_level[gi] = r_level;
  end

  logic [NUM_BTN-1:0] r_pend, r_pend_long, w_grant;
  logic [IW-1:0]      r_ptr, w_idx, w_ptr_nxt;
  logic               w_found, w_load;
  logic               r_evt_valid, r_evt_long, r_overflow;
  logic [2:0]         r_evt_btn;

  // Round-robin search upward from the pointer, wrapping at NUM_BTN-1.
  always_comb begin
    int unsigned j;
    j       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      j = (32'(r_ptr) + k) % NUM_BTN;
      if (!w_found && r_pend[IW'(j)]) begin
        w_found = 1'b1;
        w_idx   = IW'(j);
      end
    end
  end

  assign w_load    = !r_evt_valid || i_evt_ready;
  assign w_ptr_nxt = (32'(w_idx) == NUM_BTN - 1) ? '0 : w_idx + IW'(1);

  always_comb begin
    w_grant = '0;
    if (w_load && w_found) w_grant[w_idx] = 1'b1;
  end

  // A grant and a new post on the same button: grant takes the old event, post re-arms pend.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pend      <= '0;
      r_pend_long <= '0;
      r_ptr       <= '0;
      r_evt_valid <= 1'b0;
      r_evt_btn   <= '0;
      r_evt_long  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_pend      <= (r_pend & ~w_grant) | w_post;
      r_pend_long <= (r_pend_long & ~w_post) | w_post_long;
      r_overflow  <= |(r_pend & ~w_grant & w_post);
      if (w_load) begin
        if (w_found) begin
          r_evt_valid <= 1'b1;
          r_evt_btn   <= 3'(w_idx);
          r_evt_long  <= r_pend_long[w_idx];
          r_ptr       <= w_ptr_nxt;
        end else begin
          r_evt_valid <= 1'b0;
        end
      end
    end
  end

  assign o_evt_valid = r_evt_valid;
  assign o_evt_btn   = r_evt_btn;
  assign o_evt_long  = r_evt_long;
  assign o_overflow  = r_overflow;

endmodule
